banco_de_registro_param: RTL and testbench
==========================================

Name: banco_de_registro_param

Overview:
Parametrised successor to the team's 32x32 register bank. It has a clocked write port, two registered read ports with write-first forwarding, and an optional hardwired zero register. It also has a sequenced bulk-clear FSM that walks every address. It sits in the datapath between decode and the ALU operand muxes.

Parameters:
ANCHO, 32, data width in bits (>=1)
PROFUNDIDAD, 32, number of registers (>=2, need not be a power of two)
CERO_FIJO, 1, 1 = register 0 always reads 0 and ignores writes
DIR_W, $clog2(PROFUNDIDAD), address width (localparam, derived)

Ports:
clk  in  1  sole clock, rising-edge
rst  in  1  asynchronous, active-high reset
we  in  1  write enable (1 = write this cycle)
direccion  in  DIR_W  write address
dato  in  ANCHO  write data
rd_en_1  in  1  read request, port 1
dato_1  in  DIR_W  read address, port 1
rd_en_2  in  1  read request, port 2
dato_2  in  DIR_W  read address, port 2
limpiar  in  1  start bulk clear (level sampled on clock edge)
salida_1  out  ANCHO  read data, port 1 (registered)
salida_2  out  ANCHO  read data, port 2 (registered)
valido_1  out  1  salida_1 updated this cycle
valido_2  out  1  salida_2 updated this cycle
ocupado  out  1  bulk clear in progress

Behaviour:
- Clock and reset: one clock `clk`. `rst` is asynchronous and active-high.
- Reset (async): all PROFUNDIDAD registers cleared to 0. salida_1/2=0, valido_1/2=0, ocupado=0, FSM=REPOSO, clear counter=0.
- Write: on a rising edge with we=1 and ocupado=0, mem[direccion] <= dato.
  - Write ignored if direccion >= PROFUNDIDAD.
  - Write ignored if CERO_FIJO=1 and direccion=0.
  - Write ignored while ocupado=1, including the edge that samples limpiar.
- Read latency 1 cycle. On an edge with rd_en_n=1: salida_n <= value of mem[dato_n]; valido_n <= 1.
  - With rd_en_n=0: salida_n holds its previous value; valido_n <= 0.
- Forwarding (write-first): if the same edge has an accepted write to address A and a read of A, salida_n gets the new dato, not the old content.
- Read of an address >= PROFUNDIDAD returns 0. Read of address 0 with CERO_FIJO=1 returns 0. Both still assert valido.
- The two ports are independent. Both ports reading the same address is legal and returns identical data.
- Bulk-clear FSM, states REPOSO and LIMPIANDO:
  - REPOSO -> LIMPIANDO when limpiar=1 on an edge. Counter <= 0; ocupado <= 1 from the next cycle.
  - In LIMPIANDO, each edge writes mem[counter] <= 0 and increments counter. One address per cycle.
  - When counter = PROFUNDIDAD-1 is cleared, state -> REPOSO, ocupado <= 0. Total ocupado duration = exactly PROFUNDIDAD cycles.
  - limpiar while already in LIMPIANDO is ignored; it does not restart the walk.
  - Reads during LIMPIANDO are accepted, return 0, and assert valido.
  - rst during LIMPIANDO aborts immediately to the reset state.
- If limpiar and we both arrive on the same edge in REPOSO, the write is dropped; clear has priority.
- No combinational path from any input to any output.

Decomposition:
- Package banco_pkg holds the FSM state encoding (REPOSO=1'b0, LIMPIANDO=1'b1) and the default ANCHO/PROFUNDIDAD constants shared with the decode stage.
- One natural sub-module: banco_limpieza_fsm (state register, address counter, ocupado). It drives an internal clear-write enable and address into the array.
- The storage array, write logic and read/forward logic stay in the top.

Test Plan:
- Reset: assert rst mid-cycle with random array contents, then read all addresses -> every salida=0, valido=1 one cycle after each rd_en.
- Basic write/read: write 0xDEADBEEF to reg 5; next cycle read reg 5 on port 1 and port 2 -> both salida=0xDEADBEEF one cycle later.
- Forwarding: write 0x12345678 to reg 9 and read reg 9 on both ports on the same edge -> salida_1=salida_2=0x12345678 on the next cycle.
- Zero register: CERO_FIJO=1, write 0xFFFFFFFF to reg 0, then read reg 0 -> 0. Same test with CERO_FIJO=0 -> 0xFFFFFFFF.
- Bulk clear: fill all regs with 0xA5A5A5A5, pulse limpiar for 3 cycles.
  - ocupado high for exactly 32 cycles (no restart from the repeated pulse).
  - Writes during the clear are dropped.
  - All reads afterwards return 0.
- Non-power-of-two depth: PROFUNDIDAD=20, write/read address 25 -> write ignored, read returns 0 with valido=1. Clear takes 20 cycles. rst at clear cycle 7 -> ocupado=0 immediately.

Source files
------------

// File: rtl/banco_pkg.sv
// rtl/banco_pkg.sv - shared FSM encoding and default sizes for the register bank
package banco_pkg;

    typedef enum logic {
        REPOSO    = 1'b0,
        LIMPIANDO = 1'b1
    } estado_t;

    localparam int ANCHO_DEF       = 32;
    localparam int PROFUNDIDAD_DEF = 32;

endpackage

// File: rtl/banco_de_registro_param_if.sv
// rtl/banco_de_registro_param_if.sv - write/read/clear bus of the register bank
interface banco_de_registro_param_if #(
    parameter int ANCHO = 32,
    parameter int DIR_W = 5
);
    logic             we;
    logic [DIR_W-1:0] direccion;
    logic [ANCHO-1:0] dato;
    logic             rd_en_1;
    logic [DIR_W-1:0] dato_1;
    logic             rd_en_2;
    logic [DIR_W-1:0] dato_2;
    logic             limpiar;
    logic [ANCHO-1:0] salida_1;
    logic [ANCHO-1:0] salida_2;
    logic             valido_1;
    logic             valido_2;
    logic             ocupado;

    modport master (
        output we, direccion, dato, rd_en_1, dato_1, rd_en_2, dato_2, limpiar,
        input  salida_1, salida_2, valido_1, valido_2, ocupado
    );

    modport slave (
        input  we, direccion, dato, rd_en_1, dato_1, rd_en_2, dato_2, limpiar,
        output salida_1, salida_2, valido_1, valido_2, ocupado
    );
endinterface

// File: rtl/banco_limpieza_fsm.sv
// rtl/banco_limpieza_fsm.sv - bulk-clear sequencer, zeroes one address per cycle
module banco_limpieza_fsm
    import banco_pkg::*;
#(
    parameter int PROFUNDIDAD = PROFUNDIDAD_DEF,
    parameter int DIR_W       = $clog2(PROFUNDIDAD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             limpiar,
    output logic             ocupado,
    output logic             clr_we,
    output logic [DIR_W-1:0] clr_dir
);
    localparam logic [DIR_W-1:0] ULTIMA = DIR_W'(PROFUNDIDAD - 1);

    estado_t          estado_q, estado_d;
    logic [DIR_W-1:0] cnt_q, cnt_d;
    logic             ocupado_q, ocupado_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= REPOSO;
            cnt_q     <= '0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            ocupado_q <= ocupado_d;
        end
    end

    // limpiar is only looked at in REPOSO, so repeated pulses never restart the walk
    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        ocupado_d = ocupado_q;
        clr_we    = 1'b0;
        case (estado_q)
            REPOSO: begin
                if (limpiar) begin
                    estado_d  = LIMPIANDO;
                    cnt_d     = '0;
                    ocupado_d = 1'b1;
                end
            end
            LIMPIANDO: begin
                clr_we = 1'b1;
                if (cnt_q == ULTIMA) begin
                    estado_d  = REPOSO;
                    cnt_d     = '0;
                    ocupado_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    assign ocupado = ocupado_q;
    assign clr_dir = cnt_q;

endmodule

// File: rtl/banco_de_registro_param.sv
// rtl/banco_de_registro_param.sv - parametrised register bank, 1 write / 2 registered reads
module banco_de_registro_param
    import banco_pkg::*;
#(
    parameter int ANCHO       = ANCHO_DEF,
    parameter int PROFUNDIDAD = PROFUNDIDAD_DEF,
    parameter bit CERO_FIJO   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    banco_de_registro_param_if.slave   bus
);
    localparam int               DIR_W    = $clog2(PROFUNDIDAD);
    localparam logic [DIR_W:0]   PROF_EXT = (DIR_W + 1)'(PROFUNDIDAD);

    logic [ANCHO-1:0] mem_q [PROFUNDIDAD];
    logic [ANCHO-1:0] mem_d [PROFUNDIDAD];
    logic [ANCHO-1:0] salida_q [2];
    logic [ANCHO-1:0] salida_d [2];
    logic             valido_q [2];
    logic             valido_d [2];
    logic [DIR_W-1:0] rd_dir [2];
    logic             rd_en [2];

    logic             ocupado;
    logic             clr_we;
    logic [DIR_W-1:0] clr_dir;
    logic             escritura_ok;

    banco_limpieza_fsm #(
        .PROFUNDIDAD (PROFUNDIDAD),
        .DIR_W       (DIR_W)
    ) u_limpieza (
        .clk     (clk),
        .rst     (rst),
        .limpiar (bus.limpiar),
        .ocupado (ocupado),
        .clr_we  (clr_we),
        .clr_dir (clr_dir)
    );

    function automatic logic en_rango(input logic [DIR_W-1:0] a);
        return {1'b0, a} < PROF_EXT;
    endfunction

    // a limpiar edge in REPOSO also drops the write
    assign escritura_ok = bus.we && !ocupado && !bus.limpiar && en_rango(bus.direccion)
                          && !(CERO_FIJO && (bus.direccion == '0));

    assign rd_dir = '{bus.dato_1, bus.dato_2};
    assign rd_en  = '{bus.rd_en_1, bus.rd_en_2};

    always_comb begin
        mem_d = mem_q;
        if (clr_we) begin
            mem_d[clr_dir] = '0;
        end else if (escritura_ok) begin
            mem_d[bus.direccion] = bus.dato;
        end
    end

    // write-first: an accepted write to the read address bypasses the array
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            salida_d[p] = salida_q[p];
            valido_d[p] = rd_en[p];
            if (rd_en[p]) begin
                if (ocupado || !en_rango(rd_dir[p]) || (CERO_FIJO && (rd_dir[p] == '0))) begin
                    salida_d[p] = '0;
                end else if (escritura_ok && (rd_dir[p] == bus.direccion)) begin
                    salida_d[p] = bus.dato;
                end else begin
                    salida_d[p] = mem_q[rd_dir[p]];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            salida_q <= '{default: '0};
            valido_q <= '{default: 1'b0};
        end else begin
            mem_q    <= mem_d;
            salida_q <= salida_d;
            valido_q <= valido_d;
        end
    end

    assign bus.salida_1 = salida_q[0];
    assign bus.salida_2 = salida_q[1];
    assign bus.valido_1 = valido_q[0];
    assign bus.valido_2 = valido_q[1];
    assign bus.ocupado  = ocupado;

endmodule

// File: tb/tb_banco_de_registro_param.sv
// tb/tb_banco_de_registro_param.sv - self-checking bench: 32-deep zero-reg bank and 20-deep plain bank
module tb_banco_de_registro_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i [2];
    logic        we_i  [2];
    logic        lim_i [2];
    logic        rd1_i [2];
    logic        rd2_i [2];
    logic [4:0]  dir_i [2];
    logic [4:0]  a1_i  [2];
    logic [4:0]  a2_i  [2];
    logic [31:0] dat_i [2];

    logic [31:0] obs_s1 [2];
    logic [31:0] obs_s2 [2];
    logic        obs_v1 [2];
    logic        obs_v2 [2];
    logic        obs_oc [2];

    banco_de_registro_param_if #(.ANCHO(32), .DIR_W(5)) bus_a ();
    banco_de_registro_param_if #(.ANCHO(32), .DIR_W(5)) bus_b ();

    assign bus_a.we = we_i[0];   assign bus_a.direccion = dir_i[0]; assign bus_a.dato = dat_i[0];
    assign bus_a.rd_en_1 = rd1_i[0]; assign bus_a.dato_1 = a1_i[0];
    assign bus_a.rd_en_2 = rd2_i[0]; assign bus_a.dato_2 = a2_i[0];
    assign bus_a.limpiar = lim_i[0];
    assign bus_b.we = we_i[1];   assign bus_b.direccion = dir_i[1]; assign bus_b.dato = dat_i[1];
    assign bus_b.rd_en_1 = rd1_i[1]; assign bus_b.dato_1 = a1_i[1];
    assign bus_b.rd_en_2 = rd2_i[1]; assign bus_b.dato_2 = a2_i[1];
    assign bus_b.limpiar = lim_i[1];

    assign obs_s1[0] = bus_a.salida_1; assign obs_s2[0] = bus_a.salida_2;
    assign obs_v1[0] = bus_a.valido_1; assign obs_v2[0] = bus_a.valido_2;
    assign obs_oc[0] = bus_a.ocupado;
    assign obs_s1[1] = bus_b.salida_1; assign obs_s2[1] = bus_b.salida_2;
    assign obs_v1[1] = bus_b.valido_1; assign obs_v2[1] = bus_b.valido_2;
    assign obs_oc[1] = bus_b.ocupado;

    banco_de_registro_param #(.ANCHO(32), .PROFUNDIDAD(32), .CERO_FIJO(1'b1)) dut_a (
        .clk (clk), .rst (rst_i[0]), .bus (bus_a)
    );
    banco_de_registro_param #(.ANCHO(32), .PROFUNDIDAD(20), .CERO_FIJO(1'b0)) dut_b (
        .clk (clk), .rst (rst_i[1]), .bus (bus_b)
    );

    // Reference model: plain array plus "cycles of clearing left" countdown
    logic [31:0] m [2][32];
    int          rem [2];
    int          dep [2]  = '{32, 20};
    bit          cero [2] = '{1'b1, 1'b0};
    logic [31:0] es1 [2];
    logic [31:0] es2 [2];
    logic        ev1 [2];
    logic        ev2 [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] rv(input int k, input logic [4:0] a, input bit acc);
        if (rem[k] != 0 || int'(a) >= dep[k] || (cero[k] && a == 5'd0)) return 32'h0;
        if (acc && a == dir_i[k]) return dat_i[k];
        return m[k][a];
    endfunction

    task automatic model_edge(input int k);
        bit busy;
        bit acc;
        busy = (rem[k] != 0);
        acc  = we_i[k] && !busy && !lim_i[k] && int'(dir_i[k]) < dep[k]
               && !(cero[k] && dir_i[k] == 5'd0);
        ev1[k] = rd1_i[k];
        ev2[k] = rd2_i[k];
        if (rd1_i[k]) es1[k] = rv(k, a1_i[k], acc);
        if (rd2_i[k]) es2[k] = rv(k, a2_i[k], acc);
        if (busy) begin
            m[k][dep[k] - rem[k]] = 32'h0;
            rem[k]--;
        end else if (lim_i[k]) begin
            rem[k] = dep[k];
        end else if (acc) begin
            m[k][dir_i[k]] = dat_i[k];
        end
    endtask

    task automatic reset_model(input int k);
        for (int i = 0; i < 32; i++) m[k][i] = 32'h0;
        rem[k] = 0;
        es1[k] = 32'h0; es2[k] = 32'h0;
        ev1[k] = 1'b0;  ev2[k] = 1'b0;
    endtask

    task automatic idle(input int k);
        we_i[k] = 1'b0; lim_i[k] = 1'b0; rd1_i[k] = 1'b0; rd2_i[k] = 1'b0;
        dir_i[k] = 5'd0; a1_i[k] = 5'd0; a2_i[k] = 5'd0; dat_i[k] = 32'h0;
    endtask

    task automatic rand_in(input int k, input bit allow_lim);
        we_i[k]  = 1'($urandom_range(0, 1));
        dir_i[k] = 5'($urandom_range(0, 31));
        dat_i[k] = $urandom;
        rd1_i[k] = 1'($urandom_range(0, 1));
        a1_i[k]  = 5'($urandom_range(0, 31));
        rd2_i[k] = 1'($urandom_range(0, 1));
        a2_i[k]  = 5'($urandom_range(0, 31));
        lim_i[k] = allow_lim && ($urandom_range(0, 49) == 0);
    endtask

    task automatic check_outputs(input int k);
        chk($sformatf("salida_1[%0d]", k), obs_s1[k], es1[k]);
        chk($sformatf("valido_1[%0d]", k), {31'b0, obs_v1[k]}, {31'b0, ev1[k]});
        chk($sformatf("salida_2[%0d]", k), obs_s2[k], es2[k]);
        chk($sformatf("valido_2[%0d]", k), {31'b0, obs_v2[k]}, {31'b0, ev2[k]});
        chk($sformatf("ocupado[%0d]", k), {31'b0, obs_oc[k]}, {31'b0, rem[k] != 0});
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) model_edge(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_outputs(k);
    endtask

    // Reset asserted mid-cycle; outputs must drop without waiting for a clock edge
    task automatic mid_rst(input int k);
        #2;
        rst_i[k] = 1'b1;
        #1;
        reset_model(k);
        check_outputs(k);
        #1;
        rst_i[k] = 1'b0;
    endtask

    task automatic write_rd(input int k, input logic [4:0] d, input logic [31:0] v, input bit rd);
        we_i[k] = 1'b1; dir_i[k] = d; dat_i[k] = v;
        rd1_i[k] = rd; a1_i[k] = d; rd2_i[k] = rd; a2_i[k] = d;
    endtask

    task automatic read_both(input int k, input logic [4:0] d);
        we_i[k] = 1'b0; rd1_i[k] = 1'b1; a1_i[k] = d; rd2_i[k] = 1'b1; a2_i[k] = d;
    endtask

    initial begin
        int          cnt;
        logic [31:0] acum;

        for (int k = 0; k < 2; k++) begin
            rst_i[k] = 1'b1;
            idle(k);
            reset_model(k);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_outputs(k);
        rst_i[0] = 1'b0;
        rst_i[1] = 1'b0;

        // random fill, then asynchronous reset and a full read-back of zeros
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < 2; k++) begin
                rand_in(k, 1'b0);
                we_i[k] = 1'b1; dir_i[k] = 5'(i);
            end
            tick();
        end
        idle(0); idle(1);
        mid_rst(0);
        for (int i = 0; i < 32; i++) begin
            rd1_i[0] = 1'b1; a1_i[0] = 5'(i);
            rd2_i[0] = 1'b1; a2_i[0] = 5'(31 - i);
            tick();
        end
        idle(0);

        // basic write then read
        write_rd(0, 5'd5, 32'hDEADBEEF, 1'b0);
        tick();
        read_both(0, 5'd5);
        tick();
        chk("basic_p1", obs_s1[0], 32'hDEADBEEF);
        chk("basic_p2", obs_s2[0], 32'hDEADBEEF);

        // same-edge forwarding
        write_rd(0, 5'd9, 32'h12345678, 1'b1);
        tick();
        chk("fwd_p1", obs_s1[0], 32'h12345678);
        chk("fwd_p2", obs_s2[0], 32'h12345678);

        // zero register, hardwired on A and ordinary on B
        write_rd(0, 5'd0, 32'hFFFFFFFF, 1'b0);
        write_rd(1, 5'd0, 32'hFFFFFFFF, 1'b0);
        tick();
        read_both(0, 5'd0);
        read_both(1, 5'd0);
        tick();
        chk("cero_fijo1", obs_s1[0], 32'h0);
        chk("cero_fijo0", obs_s1[1], 32'hFFFFFFFF);
        idle(0); idle(1);

        // bulk clear of a full array with a 3-cycle limpiar pulse and writes during the walk
        for (int i = 0; i < 32; i++) begin
            write_rd(0, 5'(i), 32'hA5A5A5A5, 1'b0);
            tick();
        end
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            rand_in(0, 1'b0);
            lim_i[0] = (c < 3);
            we_i[0]  = (c < 32);
            tick();
            cnt += int'(obs_oc[0]);
        end
        chk("ocupado_len_32", 32'(cnt), 32'd32);
        idle(0);
        acum = 32'h0;
        for (int i = 0; i < 32; i++) begin
            read_both(0, 5'(i));
            tick();
            acum |= obs_s1[0];
        end
        chk("post_clear_zero", acum, 32'h0);
        idle(0);

        // non-power-of-two depth: out-of-range address
        write_rd(1, 5'd25, 32'hCAFEF00D, 1'b0);
        tick();
        read_both(1, 5'd25);
        tick();
        chk("oor_dato", obs_s1[1], 32'h0);
        chk("oor_valido", {31'b0, obs_v1[1]}, 32'd1);
        idle(1);

        cnt = 0;
        lim_i[1] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            lim_i[1] = 1'b0;
            cnt += int'(obs_oc[1]);
        end
        chk("ocupado_len_20", 32'(cnt), 32'd20);

        lim_i[1] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            lim_i[1] = 1'b0;
        end
        mid_rst(1);
        chk("rst_abort", {31'b0, obs_oc[1]}, 32'd0);

        // free-running random traffic on both banks
        for (int n = 0; n < 400; n++) begin
            rand_in(0, 1'b1);
            rand_in(1, 1'b1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
